multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
Main control FSM for the multi-cycle RV32I core variant. It sequences the shared datapath: one ALU, one unified memory, and a 4-input result mux whose outputs feed the PC and the register file. Each instruction is split into 3–5 states. The block drives every datapath enable and select from the current state and the instruction fields held in the instruction register.

Parameters:
- ILLEGAL_HALT, default 0. If 0, an illegal opcode returns to FETCH. If 1, it enters HALT until reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- op  in  7  instruction opcode, Instr[6:0].
- funct3  in  3  Instr[14:12].
- funct7b5  in  1  Instr[30].
- Zero  in  1  ALU result == 0.
- Neg  in  1  ALU result bit 31.
- PCWrite  out  1  load PC from Result.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  latch Instr and OldPC.
- ResultSrc  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt.
- ALUSrcA  out  2  ALU input A: 00 PC, 01 OldPC, 10 A (rs1).
- ALUSrcB  out  2  ALU input B: 00 WriteData (rs2), 01 ImmExt, 10 constant 4.
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- ImmSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- RegWrite  out  1  register file write enable.
- Illegal  out  1  one-cycle pulse on an undecodable opcode.

Behaviour:
- Reset:
  - rst = 0 forces state RESET immediately.
  - In RESET all outputs are 0; ALUControl and ImmSrc are 000.
  - After rst deasserts, RESET goes to FETCH on the next edge, so the first FETCH occurs one cycle after release.
- Outputs are Moore, decoded from the state only, with three exceptions:
  - ALUControl depends on funct3/funct7b5 when ALUOp = 10.
  - PCWrite in BRANCH depends on Zero/Neg.
  - ImmSrc is decoded from op in every state.
- Unlisted outputs are 0 in every state.
- State table (state: asserted outputs -> next state):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCWrite=1 -> DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jal target into ALUOut). Next state by op:
    - 0000011, 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR1
    - 0110111 -> LUI
    - any other op -> Illegal=1, then FETCH or HALT per ILLEGAL_HALT.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 -> MEMREAD if op = lw, else MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1 -> MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 -> FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=taken -> FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> ALUWB (rd = OldPC+4).
  - JALR1: ALUSrcA=10, ALUSrcB=01, ALUOp=00 -> JALR2.
  - JALR2: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> ALUWB.
  - LUI: ResultSrc=11, RegWrite=1 -> FETCH.
  - HALT: all outputs 0; stays in HALT until reset.
- Branch taken condition (Neg is the raw sign bit; overflow is ignored by design):
  - funct3 000: Zero.
  - funct3 001: !Zero.
  - funct3 100: Neg.
  - funct3 101: !Neg.
  - any other funct3: not taken, no Illegal pulse.
- ALU decode:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10, by funct3:
    - 000: sub only if op = R-type and funct7b5 = 1, else add.
    - 010: slt.
    - 100: xor.
    - 110: or.
    - 111: and.
    - others: add.
- ImmSrc by op: lw/I-ALU/jalr -> 000, sw -> 001, branch -> 010, jal -> 011, lui -> 100, else 000.
- Latency in cycles, including FETCH:
  - lw 5; sw 4; R-type and I-ALU 4; branch 3; lui 3; jal 4; jalr 5.
- Reset mid-instruction:
  - Asynchronous return to RESET; MemWrite and RegWrite drop in the same cycle, with no partial write on the next edge.
- Inputs are sampled only at state-transition edges. op is stable from DECODE onward because IRWrite is asserted only in FETCH.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - state encoding (4 bits)
  - opcode constants
  - ALUOp, ALUControl, ResultSrc, ALUSrcA/B and ImmSrc localparams.
- One sub-module, alu_decoder: a purely combinational map from (ALUOp, funct3, funct7b5, op[5]) to ALUControl.
- The FSM, the branch logic and the ImmSrc decode stay in multicycle_controller.

Test Plan:
- Reset then release:
  - Outputs are all 0 during reset.
  - Cycle 1 after release is RESET; cycle 2 is FETCH with IRWrite=1, PCWrite=1, ResultSrc=10, ALUSrcB=10.
- op = 0000011 (lw): state trace FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - RegWrite=1 only in the 5th cycle, with ResultSrc=01.
  - AdrSrc=1 in MEMREAD.
- op = 0110011, funct3 = 000, funct7b5 = 1 (sub): ALUControl=001 in EXECR; ALUWB has RegWrite=1, ResultSrc=00; 4 cycles total.
- op = 1100011, funct3 = 001 (bne):
  - Zero=0 -> PCWrite=1 in BRANCH.
  - Repeat with Zero=1 -> PCWrite=0.
  - Both cases return to FETCH after 3 cycles.
- op = 1101111 (jal): JAL state has PCWrite=1, ResultSrc=00; then ALUWB with RegWrite=1; ImmSrc=011 throughout.
- Illegal and reset cases:
  - op = 1111111 with ILLEGAL_HALT=0: Illegal pulses for exactly 1 cycle, then FETCH.
  - Same with ILLEGAL_HALT=1: stays in HALT with all outputs 0.
  - rst asserted during MEMWRITE: MemWrite falls immediately.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes,
// datapath select codes and the per-state Moore control word.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_LUI, S_HALT
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
    } ctrl_t;

    // Moore control word for a state; BRANCH's PCWrite is added outside.
    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.result_src = RES_ALURES;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR, S_JALR1: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: c.reg_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_SUB;
            end
            S_JAL, S_JALR2: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_write  = 1'b1;
            end
            S_LUI: begin
                c.result_src = RES_IMM;
                c.reg_write  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation select from ALUOp and the instruction function fields.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        // NOTE: default first so every path assigns alu_control and no latch is inferred.
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type from I-ALU: addi never subtracts.
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b100:  alu_control = ALU_XOR;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences the shared ALU, memory
// and result mux, with Moore outputs registered alongside the state.
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       Neg,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic       Illegal
);

    state_t state, next_state;
    ctrl_t  ctrl_q;
    logic   op_known;
    logic   taken;

    always_comb begin
        op_known = 1'b1;
        case (state)
            S_RESET:  next_state = S_FETCH;
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECR;
                    OP_I:         next_state = S_EXECI;
                    OP_BR:        next_state = S_BRANCH;
                    OP_JAL:       next_state = S_JAL;
                    OP_JALR:      next_state = S_JALR1;
                    OP_LUI:       next_state = S_LUI;
                    default: begin
                        op_known   = 1'b0;
                        next_state = ILLEGAL_HALT ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR:  next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: next_state = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL: next_state = S_ALUWB;
            S_JALR1:   next_state = S_JALR2;
            S_JALR2:   next_state = S_ALUWB;
            S_HALT:    next_state = S_HALT;
            default:   next_state = S_FETCH;
        endcase
    end

    // NOTE: the control word is computed for next_state and registered with it, so
    // outputs are glitch-free Moore values and the async reset clears them with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_RESET;
            ctrl_q <= '0;
        end else begin
            state  <= next_state;
            ctrl_q <= state_ctrl(next_state);
        end
    end

    // Neg is the raw sign bit of rs1-rs2; overflow is deliberately ignored.
    always_comb begin
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = !Zero;
            3'b100:  taken = Neg;
            3'b101:  taken = !Neg;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        ImmSrc = IMM_I;
        if (state != S_RESET && state != S_HALT) begin
            case (op)
                OP_SW:   ImmSrc = IMM_S;
                OP_BR:   ImmSrc = IMM_B;
                OP_JAL:  ImmSrc = IMM_J;
                OP_LUI:  ImmSrc = IMM_U;
                default: ImmSrc = IMM_I;
            endcase
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (ctrl_q.alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

    assign PCWrite   = ctrl_q.pc_write | ((state == S_BRANCH) & taken);
    assign AdrSrc    = ctrl_q.adr_src;
    assign MemWrite  = ctrl_q.mem_write;
    assign IRWrite   = ctrl_q.ir_write;
    assign ResultSrc = ctrl_q.result_src;
    assign ALUSrcA   = ctrl_q.alu_src_a;
    assign ALUSrcB   = ctrl_q.alu_src_b;
    assign RegWrite  = ctrl_q.reg_write;
    assign Illegal   = (state == S_DECODE) & !op_known;

endmodule
